// File: rtl/fft_tile_pkg.sv
// rtl/fft_tile_pkg.sv - shared types and constants for the FFT tile lane scheduler
// Contents: FFT_LANES lane count, lane_id_t lane index type, sched_state_e input FSM states.
package fft_tile_pkg;

  localparam int FFT_LANES = 4;
  localparam int FFT_LW    = $clog2(FFT_LANES);

  typedef logic [FFT_LW-1:0] lane_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

endpackage

// File: rtl/fft_tag_fifo.sv
// rtl/fft_tag_fifo.sv - lane-ID FIFO recording the order of frames in flight in the core
// Ports: clk_i/rst_i clock and sync active-high reset; push_i/din_i write a tag;
//        pop_i retires the head; full_o/empty_o status; head_o oldest tag.
// A push while full is accepted only when a pop happens in the same cycle.
module fft_tag_fifo
  import fft_tile_pkg::*;
#(
  parameter int WIDTH = FFT_LW,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_lane_sched.sv
// rtl/fft_lane_sched.sv - frame-level round-robin scheduler sharing one FFT core among lanes
// Ports: clk_line/clk_line_rst_high clock and sync active-high reset;
//        stream_in_* packed per-lane input streams; core_in_* stream to the core;
//        core_out_* stream from the core; stream_out_* packed per-lane output streams;
//        frames_done per-lane 16-bit completed output frame counters.
// Macro FFT_SCHED_STATS_EN builds the frames_done counters; otherwise frames_done is 0.
module fft_lane_sched
  import fft_tile_pkg::*;
#(
  parameter int BW        = 32,
  parameter int BWB       = BW/8,
  parameter int LANES     = FFT_LANES,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic [LANES-1:0]     stream_in_TVALID,
  input  logic [LANES-1:0]     stream_in_TLAST,
  input  logic [LANES*BW-1:0]  stream_in_TDATA,
  input  logic [LANES*BWB-1:0] stream_in_TKEEP,
  output logic [LANES-1:0]     stream_in_TREADY,
  output logic                 core_in_TVALID,
  output logic                 core_in_TLAST,
  output logic [BW-1:0]        core_in_TDATA,
  output logic [BWB-1:0]       core_in_TKEEP,
  input  logic                 core_in_TREADY,
  input  logic                 core_out_TVALID,
  input  logic                 core_out_TLAST,
  input  logic [BW-1:0]        core_out_TDATA,
  input  logic [BWB-1:0]       core_out_TKEEP,
  output logic                 core_out_TREADY,
  output logic [LANES-1:0]     stream_out_TVALID,
  output logic [LANES-1:0]     stream_out_TLAST,
  output logic [LANES*BW-1:0]  stream_out_TDATA,
  output logic [LANES*BWB-1:0] stream_out_TKEEP,
  input  logic [LANES-1:0]     stream_out_TREADY,
  output logic [LANES*16-1:0]  frames_done
);

  localparam int LW = $clog2(LANES);

  sched_state_e  state_q;
  logic [LW-1:0] grant_q, rr_ptr_q, rr_ptr_d;
  logic [LW-1:0] win;
  logic          found;
  logic          tag_push, tag_pop, tag_full, tag_empty;
  logic [LW-1:0] tag_head;
  logic          in_last_fire;

  // First valid lane at or after rr_ptr, searching modulo LANES.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < LANES; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= LANES) idx = idx - LANES;
      if (!found && stream_in_TVALID[idx]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  assign rr_ptr_d     = (grant_q == LW'(LANES-1)) ? '0 : grant_q + 1'b1;
  assign tag_push     = (state_q == IDLE) && found && !tag_full;
  assign in_last_fire = (state_q == BUSY) && core_in_TVALID && core_in_TREADY && core_in_TLAST;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (tag_push) begin
          grant_q <= win;
          state_q <= BUSY;
        end
        BUSY: if (in_last_fire) begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Input passthrough: zero-latency mux from the granted lane.
  always_comb begin
    core_in_TVALID   = 1'b0;
    core_in_TLAST    = 1'b0;
    core_in_TDATA    = '0;
    core_in_TKEEP    = '0;
    stream_in_TREADY = '0;
    if (state_q == BUSY) begin
      core_in_TVALID            = stream_in_TVALID[grant_q];
      core_in_TLAST             = stream_in_TLAST[grant_q];
      core_in_TDATA             = stream_in_TDATA[int'(grant_q)*BW +: BW];
      core_in_TKEEP             = stream_in_TKEEP[int'(grant_q)*BWB +: BWB];
      stream_in_TREADY[grant_q] = core_in_TREADY;
    end
  end

  fft_tag_fifo #(
    .WIDTH (LW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_line),
    .rst_i   (clk_line_rst_high),
    .push_i  (tag_push),
    .din_i   (win),
    .pop_i   (tag_pop),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .head_o  (tag_head)
  );

  // Output steering: the head tag names the lane owning the current core output frame.
  always_comb begin
    stream_out_TVALID = '0;
    stream_out_TLAST  = '0;
    stream_out_TDATA  = '0;
    stream_out_TKEEP  = '0;
    core_out_TREADY   = 1'b0;
    if (!tag_empty) begin
      stream_out_TVALID[tag_head]                  = core_out_TVALID;
      stream_out_TLAST[tag_head]                   = core_out_TLAST;
      stream_out_TDATA[int'(tag_head)*BW +: BW]    = core_out_TDATA;
      stream_out_TKEEP[int'(tag_head)*BWB +: BWB]  = core_out_TKEEP;
      core_out_TREADY                              = stream_out_TREADY[tag_head];
    end
  end

  assign tag_pop = !tag_empty && core_out_TVALID && core_out_TREADY && core_out_TLAST;

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] done_q [LANES];

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      for (int i = 0; i < LANES; i++) done_q[i] <= '0;
    end else if (tag_pop) begin
      done_q[tag_head] <= done_q[tag_head] + 16'd1;
    end
  end

  always_comb begin
    frames_done = '0;
    for (int i = 0; i < LANES; i++) frames_done[i*16 +: 16] = done_q[i];
  end
`else
  assign frames_done = '0;
`endif

endmodule

// File: tb/tb_fft_lane_sched.sv
// tb/tb_fft_lane_sched.sv - directed self-checking bench for fft_lane_sched
module tb_fft_lane_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid, in_last, in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         ci_valid, ci_last, ci_ready;
  logic [31:0]  ci_data;
  logic [3:0]   ci_keep;
  logic         co_valid, co_last, co_ready;
  logic [31:0]  co_data;
  logic [3:0]   co_keep;
  logic [3:0]   so_valid, so_last, so_ready;
  logic [127:0] so_data;
  logic [15:0]  so_keep;
  logic [63:0]  frames_done;

  int checks = 0;
  int errors = 0;

`ifdef FFT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  fft_lane_sched dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .stream_in_TVALID  (in_valid),
    .stream_in_TLAST   (in_last),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TREADY  (in_ready),
    .core_in_TVALID    (ci_valid),
    .core_in_TLAST     (ci_last),
    .core_in_TDATA     (ci_data),
    .core_in_TKEEP     (ci_keep),
    .core_in_TREADY    (ci_ready),
    .core_out_TVALID   (co_valid),
    .core_out_TLAST    (co_last),
    .core_out_TDATA    (co_data),
    .core_out_TKEEP    (co_keep),
    .core_out_TREADY   (co_ready),
    .stream_out_TVALID (so_valid),
    .stream_out_TLAST  (so_last),
    .stream_out_TDATA  (so_data),
    .stream_out_TKEEP  (so_keep),
    .stream_out_TREADY (so_ready),
    .frames_done       (frames_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 4'hF;
    in_last  = 4'h0;
    in_data  = '0;
    in_keep  = '1;
    ci_ready = 1'b1;
    co_valid = 1'b1;
    co_last  = 1'b0;
    co_data  = 32'h99;
    co_keep  = 4'hF;
    so_ready = 4'hF;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 4'h0);
    chk("rst_ci_valid", ci_valid, 1'b0);
    chk("rst_co_ready", co_ready, 1'b0);
    chk("rst_so_valid", so_valid, 4'h0);
    chk("rst_frames", frames_done, 64'h0);
    rst      = 1'b0;
    in_valid = 4'h0;
    co_valid = 1'b0;

    // Single lane: lane 2 sends 0x10..0x13
    tick();
    in_valid = 4'b0100;
    in_data[64 +: 32] = 32'h10;
    #1;
    chk("t1_arb_wait", in_ready, 4'h0);
    for (int b = 0; b < 4; b++) begin
      tick();
      in_data[64 +: 32] = 32'h10 + 32'(b);
      in_last[2] = (b == 3);
      #1;
      chk("t1_in_ready", in_ready, 4'b0100);
      chk("t1_ci_data", ci_data, 32'h10 + 32'(b));
      chk("t1_ci_last", ci_last, (b == 3));
    end
    tick();
    chk("t1_gap_ready", in_ready, 4'h0);
    chk("t1_gap_valid", ci_valid, 1'b0);
    in_valid = 4'h0;
    in_last  = 4'h0;
    for (int b = 0; b < 4; b++) begin
      co_valid = 1'b1;
      co_data  = 32'hA0 + 32'(b);
      co_last  = (b == 3);
      #1;
      chk("t1_so_valid", so_valid, 4'b0100);
      chk("t1_so_data", so_data, 128'(32'hA0 + 32'(b)) << 64);
      chk("t1_co_ready", co_ready, 1'b1);
      tick();
    end
    co_valid = 1'b0;
    co_last  = 1'b0;
    #1;
    chk("t1_drained", co_ready, 1'b0);
    chk("t1_so_idle", so_valid, 4'h0);
    chk("t1_frames", frames_done, STATS ? (64'h1 << 32) : 64'h0);

    // Round-robin with 2-beat frames on all lanes
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'hF;
    co_valid = 1'b1;
    co_last  = 1'b1;
    co_data  = 32'h0;
    for (int f = 0; f < 5; f++) begin
      in_last = 4'h0;
      lane_data(32'h200);
      #1;
      chk("rr_gap", ci_valid, 1'b0);
      tick();
      chk("rr_grant", in_ready, 128'(1) << (f % 4));
      chk("rr_beat0", ci_data, 32'h200 + 32'(f % 4));
      tick();
      in_last = 4'hF;
      lane_data(32'h210);
      #1;
      chk("rr_beat1", ci_data, 32'h210 + 32'(f % 4));
      chk("rr_last", ci_last, 1'b1);
      tick();
    end
    in_valid = 4'h0;
    co_valid = 1'b0;

    // Tag FIFO full: four single-beat frames, fifth waits for a pop
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'hF;
    in_last  = 4'hF;
    lane_data(32'h300);
    for (int f = 0; f < 4; f++) begin
      tick();
      chk("full_grant", in_ready, 128'(1) << f);
      tick();
    end
    chk("full_stall", in_ready, 4'h0);
    chk("full_ci_idle", ci_valid, 1'b0);
    tick();
    chk("full_stall2", in_ready, 4'h0);
    co_valid = 1'b1;
    co_last  = 1'b1;
    co_data  = 32'h55;
    #1;
    chk("full_head0", so_valid, 4'b0001);
    chk("full_co_ready", co_ready, 1'b1);
    tick();
    co_valid = 1'b0;
    #1;
    chk("fifth_wait", in_ready, 4'h0);
    tick();
    chk("fifth_grant", in_ready, 4'b0001);
    chk("fifth_data", ci_data, 32'h300);
    tick();
    in_valid = 4'h0;
    in_last  = 4'h0;

    // Backpressure on head lane 1
    co_valid = 1'b1;
    co_last  = 1'b0;
    co_data  = 32'h77;
    so_ready = 4'b1101;
    #1;
    chk("bp_co_ready", co_ready, 1'b0);
    chk("bp_so_valid", so_valid, 4'b0010);
    chk("bp_so_data", so_data, 128'(32'h77) << 32);
    tick();
    chk("bp_hold_valid", so_valid, 4'b0010);
    chk("bp_hold_data", so_data, 128'(32'h77) << 32);
    so_ready = 4'hF;
    #1;
    chk("bp_release", co_ready, 1'b1);
    co_valid = 1'b0;

    // Reset mid-frame on lane 3
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b1000;
    in_data[96 +: 32] = 32'h400;
    tick();
    chk("mid_grant3", in_ready, 4'b1000);
    in_data[96 +: 32] = 32'h401;
    tick();
    in_data[96 +: 32] = 32'h402;
    co_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_in_ready", in_ready, 4'h0);
    chk("mid_ci_valid", ci_valid, 1'b0);
    chk("mid_co_ready", co_ready, 1'b0);
    chk("mid_so_valid", so_valid, 4'h0);
    chk("mid_frames", frames_done, 64'h0);
    rst      = 1'b0;
    co_valid = 1'b0;
    in_valid = 4'b1001;
    tick();
    chk("mid_rr0", in_ready, 4'b0001);
    in_valid = 4'h0;
    tick();

`ifdef FFT_SCHED_STATS_EN
    // 65536 lane 0 frames wrap frames_done[0]
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b0001;
    in_last  = 4'hF;
    co_valid = 1'b1;
    co_last  = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      tick();
      if (n == 65535) chk("wrap_ffff", frames_done[15:0], 16'hFFFF);
      tick();
    end
    in_valid = 4'h0;
    co_valid = 1'b0;
    chk("wrap_zero", frames_done[15:0], 16'h0);
`else
    chk("nostats_frames", frames_done, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
